// File: rtl/sdram_req_arb.sv
// rtl/sdram_req_arb.sv - command FIFO, dispatch FSM and credit-protected read return for the SDRAM controller
// One in-order command stream is split onto the controller's write and read-address channels.

module sdram_req_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;
endmodule

module sdram_req_arb #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdram_init_done,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [21:0] cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [15:0] wr_data,
   output logic [21:0] wr_addr,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [21:0] rd_addr,
   output logic        rd_avalid,
   input  logic        rd_aready,
   input  logic [15:0] rd_data,
   input  logic        rd_valid,
   output logic        rd_ready,
   output logic        busy,
   output logic        err_unexp_rd
);
   localparam int CCW = $clog2(CMD_DEPTH) + 1;
   localparam int OW  = $clog2(RSP_DEPTH) + 1;
   localparam logic [CCW-1:0] CMD_FULL  = CCW'(CMD_DEPTH);
   localparam logic [OW:0]    RSP_LIMIT = (OW+1)'(RSP_DEPTH);

   typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE_WR, ISSUE_RD} state_t;

   state_t         state_q, state_d;
   logic [21:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [15:0]    wr_data_q, wr_data_d;
   logic [OW-1:0]  outst_q, outst_d;
   logic           err_q, cmd_ready_q, cmd_ready_d;

   logic           cmd_push, cmd_pop, rd_issue, rsp_push, rsp_pop, credit_ok;
   logic [38:0]    cmd_head;
   logic [CCW-1:0] cmd_count, cmd_cnt_d;
   logic [OW-1:0]  rsp_count;
   logic [15:0]    rsp_head;
   logic [OW:0]    in_use;

   assign cmd_push = cmd_valid && cmd_ready_q;

   sdram_req_arb_fifo #(.DEPTH(CMD_DEPTH), .W(39)) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_push),
      .pop_i   (cmd_pop),
      .wdata_i ({cmd_we, cmd_addr, cmd_wdata}),
      .rdata_o (cmd_head),
      .count_o (cmd_count)
   );

   sdram_req_arb_fifo #(.DEPTH(RSP_DEPTH), .W(16)) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rsp_push),
      .pop_i   (rsp_pop),
      .wdata_i (rd_data),
      .rdata_o (rsp_head),
      .count_o (rsp_count)
   );

   // A read may only leave the queue if its response is guaranteed a slot.
   assign in_use    = {1'b0, outst_q} + {1'b0, rsp_count};
   assign credit_ok = in_use < RSP_LIMIT;

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      cmd_pop   = 1'b0;
      rd_issue  = 1'b0;
      case (state_q)
         WAIT_INIT: if (sdram_init_done) state_d = IDLE;
         IDLE: begin
            if (cmd_count != '0) begin
               if (cmd_head[38]) begin
                  cmd_pop   = 1'b1;
                  wr_addr_d = cmd_head[37:16];
                  wr_data_d = cmd_head[15:0];
                  state_d   = ISSUE_WR;
               end else if (credit_ok) begin
                  cmd_pop   = 1'b1;
                  rd_addr_d = cmd_head[37:16];
                  state_d   = ISSUE_RD;
               end
            end
         end
         ISSUE_WR: if (wr_ready) state_d = IDLE;
         ISSUE_RD: begin
            if (rd_aready) begin
               rd_issue = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = WAIT_INIT;
      endcase
   end

   assign rsp_push    = rd_valid && (outst_q != '0);
   assign rsp_pop     = rsp_valid && rsp_ready;
   assign outst_d     = outst_q + OW'(rd_issue) - OW'(rsp_push);
   assign cmd_cnt_d   = cmd_count + CCW'(cmd_push) - CCW'(cmd_pop);
   assign cmd_ready_d = cmd_cnt_d != CMD_FULL;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_INIT;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         rd_addr_q   <= '0;
         outst_q     <= '0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_addr_q   <= rd_addr_d;
         outst_q     <= outst_d;
         err_q       <= err_q | (rd_valid && (outst_q == '0));
         cmd_ready_q <= cmd_ready_d;
      end
   end

   // Outputs are forced low while rst is held so nothing handshakes during reset.
   assign cmd_ready    = cmd_ready_q && !rst;
   assign wr_valid     = (state_q == ISSUE_WR) && !rst;
   assign rd_avalid    = (state_q == ISSUE_RD) && !rst;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign rd_addr      = rd_addr_q;
   assign rd_ready     = !rst;
   assign rsp_valid    = (rsp_count != '0) && !rst;
   assign rsp_data     = rsp_valid ? rsp_head : 16'h0000;
   assign err_unexp_rd = err_q && !rst;
   assign busy         = !rst && ((cmd_count != '0) || (state_q == ISSUE_WR) ||
                                  (state_q == ISSUE_RD) || (outst_q != '0));
endmodule

// File: tb/tb_sdram_req_arb.sv
// tb/tb_sdram_req_arb.sv - directed self-checking bench for sdram_req_arb
// Controller side is driven by hand; handshakes are logged at the falling edge.

module tb_sdram_req_arb;
   logic        clk = 1'b0;
   logic        rst, sdram_init_done, cmd_valid, cmd_ready, cmd_we;
   logic [21:0] cmd_addr, wr_addr, rd_addr;
   logic [15:0] cmd_wdata, rsp_data, wr_data, rd_data;
   logic        rsp_valid, rsp_ready, wr_valid, wr_ready, rd_avalid, rd_aready;
   logic        rd_valid, rd_ready, busy, err_unexp_rd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rd_hs_cnt = 0;
   int wr_hs_cyc = 0;
   int rd_hs_cyc = 0;
   logic [37:0] wr_seen[$];
   logic [15:0] rsp_got[$];

   always #5 clk = ~clk;

   sdram_req_arb dut (
      .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .err_unexp_rd(err_unexp_rd)
   );

   // Inputs only change just after a rising edge, so these fire for the coming edge.
   always @(negedge clk) begin
      cyc++;
      if (wr_valid && wr_ready) begin
         wr_seen.push_back({wr_addr, wr_data});
         wr_hs_cyc = cyc;
      end
      if (rd_avalid && rd_aready) begin
         rd_hs_cnt++;
         rd_hs_cyc = cyc;
      end
      if (rsp_valid && rsp_ready) rsp_got.push_back(rsp_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0; rd_valid = 1'b0;
      wr_ready = 1'b0; rd_aready = 1'b0; rsp_ready = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic push_cmd(input logic we, input logic [21:0] a, input logic [15:0] d);
      int n = 0;
      while (!cmd_ready && n < 50) begin step(); n++; end
      if (!cmd_ready) check("push_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rd_hs(input int n, input string tag);
      int k = 0;
      while (rd_hs_cnt < n && k < 60) begin step(); k++; end
      check(tag, 32'(rd_hs_cnt), 32'(n));
   endtask

   task automatic wait_rd_avalid(input string tag);
      int k = 0;
      while (!rd_avalid && k < 60) begin step(); k++; end
      check(tag, 32'(rd_avalid), 32'd1);
   endtask

   task automatic ret_beat(input logic [15:0] d);
      rd_valid = 1'b1; rd_data = d;
      step();
      rd_valid = 1'b0;
   endtask

   initial begin
      int base, accepted, k;
      logic acc_now;
      logic [37:0] ent;
      sdram_init_done = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rd_data = '0;
      rst = 1'b1; cmd_valid = 1'b0; rd_valid = 1'b0;
      wr_ready = 1'b0; rd_aready = 1'b0; rsp_ready = 1'b0;

      // reset state
      step();
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_wr_valid", 32'(wr_valid), 0);
      check("rst_rd_avalid", 32'(rd_avalid), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rd_ready", 32'(rd_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err_unexp_rd), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      step();
      rst = 1'b0;
      step();
      check("post_rst_cmd_ready", 32'(cmd_ready), 1);
      check("post_rst_rd_ready", 32'(rd_ready), 1);

      // write queued before init completes
      push_cmd(1'b1, 22'h000010, 16'hA5A5);
      for (int i = 0; i < 4; i++) step();
      check("preinit_wr_valid", 32'(wr_valid), 0);
      check("preinit_busy", 32'(busy), 1);
      sdram_init_done = 1'b1;
      step();
      check("init_wr_valid_c1", 32'(wr_valid), 0);
      step();
      check("init_wr_valid_c2", 32'(wr_valid), 1);
      check("init_wr_addr", 32'(wr_addr), 32'h10);
      check("init_wr_data", 32'(wr_data), 32'hA5A5);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_wr", {15'd0, wr_valid, wr_data}, {15'd0, 1'b1, 16'hA5A5});
      end
      wr_ready = 1'b1;
      step();
      check("wr_done_valid", 32'(wr_valid), 0);

      // write then read to the top address
      push_cmd(1'b1, 22'h3FFFFF, 16'h1234);
      push_cmd(1'b0, 22'h3FFFFF, 16'h0000);
      wait_rd_avalid("b2b_rd_avalid");
      check("b2b_rd_addr", 32'(rd_addr), 32'h3FFFFF);
      rd_aready = 1'b1;
      step();
      rd_aready = 1'b0;
      check("wr_before_rd", 32'(wr_hs_cyc < rd_hs_cyc), 1);
      check("b2b_wr_addr", 32'(wr_seen[wr_seen.size()-1][37:16]), 32'h3FFFFF);
      ret_beat(16'h1234);
      check("b2b_rsp_valid", 32'(rsp_valid), 1);
      check("b2b_rsp_data", 32'(rsp_data), 32'h1234);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("b2b_rsp_drained", 32'(rsp_valid), 0);

      // credit stall with 6 reads
      rsp_got.delete();
      base = rd_hs_cnt;
      rd_aready = 1'b1;
      for (int i = 0; i < 6; i++) push_cmd(1'b0, 22'(32'h100 + i), 16'h0000);
      wait_rd_hs(base + 4, "credit_first4");
      for (int i = 0; i < 6; i++) step();
      check("credit_stall_cnt", 32'(rd_hs_cnt - base), 4);
      check("credit_stall_avalid", 32'(rd_avalid), 0);
      check("credit_stall_busy", 32'(busy), 1);
      for (int i = 0; i < 4; i++) ret_beat(16'(32'hB000 + i));
      for (int i = 0; i < 4; i++) step();
      check("credit_full_rsp_cnt", 32'(rd_hs_cnt - base), 4);
      check("credit_rsp_head", 32'(rsp_data), 32'hB000);
      rsp_ready = 1'b1;
      wait_rd_hs(base + 6, "credit_last2");
      ret_beat(16'hB004);
      ret_beat(16'hB005);
      for (int i = 0; i < 3; i++) step();
      rsp_ready = 1'b0;
      rd_aready = 1'b0;
      check("credit_rsp_count", 32'(rsp_got.size()), 6);
      for (int i = 0; i < 6 && i < rsp_got.size(); i++)
         check("credit_rsp_order", 32'(rsp_got[i]), 32'hB000 + 32'(i));

      // command FIFO fill with wr_ready low
      wr_seen.delete();
      wr_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 8; i++) begin
         cmd_valid = 1'b1; cmd_we = 1'b1;
         cmd_addr = 22'(32'h200 + accepted); cmd_wdata = 16'(32'hC000 + accepted);
         acc_now = cmd_ready;
         step();
         if (acc_now) accepted++;
      end
      check("fill_accepted", 32'(accepted), 5);
      check("fill_cmd_ready", 32'(cmd_ready), 0);
      wr_ready = 1'b1;
      step();
      check("fill_cmd_ready_hold", 32'(cmd_ready), 0);
      step();
      check("fill_cmd_ready_back", 32'(cmd_ready), 1);
      k = 0;
      while (accepted < 8 && k < 40) begin
         cmd_addr = 22'(32'h200 + accepted); cmd_wdata = 16'(32'hC000 + accepted);
         acc_now = cmd_ready;
         step();
         if (acc_now) accepted++;
         k++;
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("fill_wr_count", 32'(wr_seen.size()), 8);
      for (int i = 0; i < 8 && i < wr_seen.size(); i++) begin
         ent = wr_seen[i];
         check("fill_wr_order", {ent[37:16], 10'd0}, {22'(32'h200 + i), 10'd0});
         check("fill_wr_data", 32'(ent[15:0]), 32'hC000 + 32'(i));
      end

      // reset while a read is being issued
      base = rd_hs_cnt;
      rd_aready = 1'b1;
      push_cmd(1'b0, 22'h000040, 16'h0000);
      push_cmd(1'b0, 22'h000041, 16'h0000);
      wait_rd_hs(base + 2, "rst_mid_two_out");
      rd_aready = 1'b0;
      push_cmd(1'b0, 22'h000042, 16'h0000);
      wait_rd_avalid("rst_mid_issue");
      check("rst_mid_busy_before", 32'(busy), 1);
      rst = 1'b1;
      step();
      check("rst_mid_valids", {29'd0, wr_valid, rd_avalid, rsp_valid}, 0);
      check("rst_mid_busy", 32'(busy), 0);
      rst = 1'b0;
      step();
      check("rst_mid_after_avalid", 32'(rd_avalid), 0);
      check("rst_mid_after_busy", 32'(busy), 0);
      check("rst_mid_after_err", 32'(err_unexp_rd), 0);
      ret_beat(16'hDEAD);
      check("stray_err", 32'(err_unexp_rd), 1);
      check("stray_dropped", 32'(rsp_valid), 0);
      for (int i = 0; i < 3; i++) step();
      check("stray_err_sticky", 32'(err_unexp_rd), 1);

      // same-cycle issue and return with one read outstanding
      do_reset();
      step();
      check("err_cleared", 32'(err_unexp_rd), 0);
      rsp_got.delete();
      base = rd_hs_cnt;
      rd_aready = 1'b1;
      push_cmd(1'b0, 22'h000300, 16'h0000);
      wait_rd_hs(base + 1, "same_first");
      rd_aready = 1'b0;
      push_cmd(1'b0, 22'h000301, 16'h0000);
      wait_rd_avalid("same_second_avalid");
      rd_aready = 1'b1; rd_valid = 1'b1; rd_data = 16'hD00D;
      step();
      rd_aready = 1'b0; rd_valid = 1'b0;
      check("same_rsp_valid", 32'(rsp_valid), 1);
      check("same_rsp_data", 32'(rsp_data), 32'hD00D);
      check("same_busy_out1", 32'(busy), 1);
      ret_beat(16'hBEEF);
      step();
      check("same_busy_drained", 32'(busy), 0);
      check("same_no_err", 32'(err_unexp_rd), 0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rsp_ready = 1'b0;
      check("same_rsp_cnt", 32'(rsp_got.size()), 2);
      if (rsp_got.size() == 2) begin
         check("same_rsp0", 32'(rsp_got[0]), 32'hD00D);
         check("same_rsp1", 32'(rsp_got[1]), 32'hBEEF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
